// File: rtl/sprite_memory_writer.sv
// Sprite colour memory write front end.
// Host words enter a small FIFO with an auto-incrementing address pointer;
// a three-state arbiter shares the single memory port between video reads
// (priority) and buffered writes, with a stall guard that forces one write
// after MAX_STALL consecutive blocked cycles.
// Optional build macro: SPRITE_WRITER_COUNT_EN enables the words_written counter.
module sprite_memory_writer #(
  parameter int FIFO_DEPTH = 8,
  parameter int MEM_WORDS  = 16384,
  parameter int MAX_STALL  = 15
) (
  input  logic                          clock,
  input  logic                          reset_n,
  input  logic                          wr_valid,
  output logic                          wr_ready,
  input  logic                          wr_start,
  input  logic [13:0]                   wr_address,
  input  logic [8:0]                    wr_data,
  output logic                          wr_error,
  input  logic                          rd_req,
  input  logic [13:0]                   rd_address,
  output logic                          rd_ack,
  output logic                          rd_valid,
  output logic [8:0]                    rd_data,
  output logic [13:0]                   mem_address,
  output logic [8:0]                    mem_data,
  output logic                          mem_wren,
  input  logic [8:0]                    mem_q,
  output logic                          write_done,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic [15:0]                   words_written
);

  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int CNT_W   = PTR_W + 1;
  localparam int STALL_W = (MAX_STALL < 1) ? 1 : $clog2(MAX_STALL + 1);

  typedef enum logic [1:0] {IDLE, READ, WRITE} arb_state_t;

  arb_state_t         state_reg, state_next;
  logic [STALL_W-1:0] stall_reg, stall_next;
  logic [13:0]        ptr_reg;
  logic [PTR_W-1:0]   wr_ptr_reg, rd_ptr_reg;
  logic [CNT_W-1:0]   count_reg;
  logic [13:0]        mem_address_reg;
  logic [8:0]         mem_data_reg;
  logic               mem_wren_reg, rd_valid_reg, wr_error_reg;

  // FIFO storage: address and data of each pending write
  logic [13:0] fifo_addr [FIFO_DEPTH];
  logic [8:0]  fifo_data [FIFO_DEPTH];

  logic        push_fire, addr_bad, enq, deq, fifo_empty, force_write;
  logic [13:0] eff_addr, ptr_next;

  assign fifo_empty  = (count_reg == '0);
  assign wr_ready    = (count_reg < CNT_W'(FIFO_DEPTH));
  assign push_fire   = wr_valid && wr_ready;
  // A start address outside the memory drops the word but still handshakes
  assign addr_bad    = wr_start && (32'(wr_address) >= MEM_WORDS);
  assign enq         = push_fire && !addr_bad;
  assign eff_addr    = wr_start ? wr_address : ptr_reg;
  assign ptr_next    = (32'(eff_addr) == MEM_WORDS - 1) ? 14'd0 : eff_addr + 14'd1;
  assign force_write = !fifo_empty && (stall_reg == STALL_W'(MAX_STALL));

  // Arbiter decision and stall-guard bookkeeping for the coming cycle
  always_comb begin
    state_next = IDLE;
    if (rd_req && !force_write) begin
      state_next = READ;
    end else if (!fifo_empty) begin
      state_next = WRITE;
    end
    deq        = (state_next == WRITE);
    stall_next = stall_reg;
    if (fifo_empty || deq) begin
      stall_next = '0;
    end else if (state_next == READ) begin
      stall_next = stall_reg + STALL_W'(1);
    end
  end

  // FIFO entry write; storage needs no reset since occupancy gates its use
  always_ff @(posedge clock) begin
    if (enq) begin
      fifo_addr[wr_ptr_reg] <= eff_addr;
      fifo_data[wr_ptr_reg] <= wr_data;
    end
  end

  // Arbiter state, registered memory port and FIFO pointers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_reg       <= IDLE;
      stall_reg       <= '0;
      ptr_reg         <= '0;
      wr_ptr_reg      <= '0;
      rd_ptr_reg      <= '0;
      count_reg       <= '0;
      mem_address_reg <= '0;
      mem_data_reg    <= '0;
      mem_wren_reg    <= 1'b0;
      rd_valid_reg    <= 1'b0;
      wr_error_reg    <= 1'b0;
    end else begin
      state_reg    <= state_next;
      stall_reg    <= stall_next;
      mem_wren_reg <= deq;
      rd_valid_reg <= (state_reg == READ);
      wr_error_reg <= push_fire && addr_bad;
      if (state_next == READ) begin
        mem_address_reg <= rd_address;
      end else if (deq) begin
        mem_address_reg <= fifo_addr[rd_ptr_reg];
        mem_data_reg    <= fifo_data[rd_ptr_reg];
      end
      if (enq) begin
        ptr_reg    <= ptr_next;
        wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      end
      if (deq) begin
        rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      end
      case ({enq, deq})
        2'b10:   count_reg <= count_reg + CNT_W'(1);
        2'b01:   count_reg <= count_reg - CNT_W'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

`ifdef SPRITE_WRITER_COUNT_EN
  logic [15:0] words_written_reg;

  // Committed-write counter, wraps naturally at 16 bits
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      words_written_reg <= '0;
    end else if (deq) begin
      words_written_reg <= words_written_reg + 16'd1;
    end
  end

  assign words_written = words_written_reg;
`else
  assign words_written = '0;
`endif

  assign rd_ack      = (state_reg == READ);
  assign rd_valid    = rd_valid_reg;
  assign rd_data     = mem_q;
  assign mem_address = mem_address_reg;
  assign mem_data    = mem_data_reg;
  assign mem_wren    = mem_wren_reg;
  assign write_done  = mem_wren_reg;
  assign wr_error    = wr_error_reg;
  assign busy        = (count_reg != '0) || mem_wren_reg;
  assign fifo_count  = count_reg;

endmodule
